// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a valid/ready request
// with a valid response, and holds each instruction until decode consumes it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] immediate_ext,
    output logic        fetch_fault
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [2:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    // Branch offset and sequential step share one adder; wrap-around is silent.
    always_comb begin
        next_pc = pc + (branch_taken ? immediate_ext : 32'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    // Counter reaching the limit costs one more cycle, giving MAX_WAIT+1 WAIT cycles.
                    if (imem_rsp_valid) begin
                        instruction <= imem_rsp_data;
                        state       <= HOLD;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        if (next_pc[1:0] == 2'b00) begin
                            pc    <= next_pc;
                            state <= REQ;
                        end else begin
                            state <= FAULT;
                        end
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ);
    assign instr_valid    = (state == HOLD);
    assign fetch_fault    = (state == FAULT);
    assign imem_addr      = pc;
    assign opcode         = instruction[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; inputs driven and outputs
// sampled on the falling clock edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] immediate_ext;
    logic        fetch_fault;

    int unsigned checks = 0;
    int unsigned errors = 0;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .opcode        (opcode),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .immediate_ext (immediate_ext),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge with the DUT in REQ; leaves it in HOLD.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        check_eq("fetch_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("fetch_addr", imem_addr, exp_addr);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        instr_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        check_eq("fetch_instr_valid", 32'(instr_valid), 32'd1);
        check_eq("fetch_instruction", instruction, data);
        check_eq("fetch_pc", pc, exp_addr);
    endtask

    task automatic consume(input logic bt, input logic [31:0] imm);
        instr_ready   = 1'b1;
        branch_taken  = bt;
        immediate_ext = imm;
        @(negedge clk);
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        immediate_ext = 32'hDEAD_0001;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] held_instr;
        int unsigned phase;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_81B3;
        instr_ready    = 1'b1;
        branch_taken   = 1'b0;
        immediate_ext  = 32'h0;

        repeat (2) @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instruction", instruction, 32'h0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);

        // Everything tied high: REQ, WAIT, HOLD repeating, address stepping by 4.
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            phase    = (k - 1) % 3;
            exp_addr = 32'((k - 1) / 3) * 32'd4;
            check_eq("stream_req_valid", 32'(imem_req_valid), (phase == 0) ? 32'd1 : 32'd0);
            check_eq("stream_instr_valid", 32'(instr_valid), (phase == 2) ? 32'd1 : 32'd0);
            check_eq("stream_addr", imem_addr, exp_addr);
            if (phase == 2)
                check_eq("stream_opcode", 32'(opcode), 32'h33);
        end

        // Backpressure in HOLD.
        instr_ready = 1'b0;
        pulse_reset();
        do_fetch(32'h0, 32'h00A0_0093);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_instruction", instruction, 32'h00A0_0093);
            check_eq("bp_pc", pc, 32'h0);
            check_eq("bp_instr_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_no_req", 32'(imem_req_valid), 32'd0);
        end
        consume(1'b1, 32'h0000_0100);
        check_eq("jump_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("jump_instr_valid_drop", 32'(instr_valid), 32'd0);
        check_eq("jump_addr", imem_addr, 32'h100);

        // Backward and forward branches from 0x100.
        do_fetch(32'h100, 32'hFE00_0EE3);
        consume(1'b1, 32'hFFFF_FFF0);
        check_eq("br_back_addr", imem_addr, 32'h0F0);
        do_fetch(32'h0F0, 32'h0000_006F);
        consume(1'b1, 32'h0000_0010);
        check_eq("br_return_addr", imem_addr, 32'h100);
        do_fetch(32'h100, 32'h0000_0463);
        consume(1'b1, 32'h0000_0008);
        check_eq("br_fwd_addr", imem_addr, 32'h108);

        // Wrap past the top of the address space, then a misaligned target.
        do_fetch(32'h108, 32'h0000_0013);
        consume(1'b1, 32'hFFFF_FEF4);
        check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0013);
        consume(1'b0, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h0000_0363);
        consume(1'b1, 32'h0000_0006);
        check_eq("misalign_fault", 32'(fetch_fault), 32'd1);
        check_eq("misalign_pc_kept", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            imem_req_ready = 1'b1;
            @(negedge clk);
            check_eq("fault_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("fault_sticky", 32'(fetch_fault), 32'd1);
        end

        // Response timeout: fault exactly 16 cycles after WAIT entry.
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        pulse_reset();
        check_eq("to_fault_cleared", 32'(fetch_fault), 32'd0);
        check_eq("to_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check_eq("to_fault_timing", 32'(fetch_fault), (i == 16) ? 32'd1 : 32'd0);
        end
        repeat (3) @(negedge clk);
        check_eq("to_fault_sticky", 32'(fetch_fault), 32'd1);
        check_eq("to_no_req", 32'(imem_req_valid), 32'd0);

        // Asynchronous reset in the middle of WAIT.
        pulse_reset();
        check_eq("ar_fault_cleared", 32'(fetch_fault), 32'd0);
        do_fetch(32'h0, 32'h1234_5013);
        consume(1'b0, 32'h0);
        check_eq("ar_addr_before", imem_addr, 32'h4);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_pc_async", pc, 32'h0);
        check_eq("ar_addr_async", imem_addr, 32'h0);
        check_eq("ar_instruction_async", instruction, 32'h0);
        check_eq("ar_req_async", 32'(imem_req_valid), 32'd0);
        check_eq("ar_valid_async", 32'(instr_valid), 32'd0);

        // Stale response presented across release, through IDLE and REQ.
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("stale_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("stale_addr", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("stale_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("stale_instruction", instruction, 32'h0);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        held_instr     = 32'h0040_0113;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = held_instr;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_eq("fresh_instr_valid", 32'(instr_valid), 32'd1);
        check_eq("fresh_instruction", instruction, held_instr);
        check_eq("fresh_pc", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetches 32-bit instructions for the single-cycle core. Owns the program counter, issues word reads to instruction memory over a valid/ready request and valid response, and holds each fetched word stable for the decode stage until it is consumed. It sits directly upstream of opcode decode and immediate generation. It computes the next PC as sequential (+4) or as a branch target from the sign-extended immediate that immediate generation returns.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, response-wait cycles allowed before declaring a fetch fault (1..255).

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (equals pc).
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  instruction/opcode/pc outputs valid.
- instr_ready  in  1  downstream consumes current instruction.
- instruction  out  32  held instruction word.
- opcode  out  7  instruction[6:0].
- pc  out  32  address of the held instruction.
- branch_taken  in  1  redirect to pc + immediate_ext.
- immediate_ext  in  32  sign-extended branch offset.
- fetch_fault  out  1  sticky fault flag.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT. The FSM is Moore: imem_req_valid = (state==REQ) and instr_valid = (state==HOLD).
- Reset (async, rst_n low): state=IDLE, pc=RESET_PC, instruction=0, wait counter=0, fetch_fault=0. All outputs are 0 except pc and imem_addr, which equal RESET_PC.
- IDLE -> REQ unconditionally on the next edge.
- REQ: drive imem_addr=pc.
  - If imem_req_ready is high, go to WAIT and clear the wait counter.
  - Otherwise stay in REQ with the address held. There is no timeout in REQ.
- WAIT:
  - If imem_rsp_valid is high, capture imem_rsp_data into instruction and go to HOLD.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT with no response, go to FAULT.
- HOLD:
  - instruction, opcode and pc are stable while instr_valid=1 and instr_ready=0.
  - When instr_ready=1, sample branch_taken and immediate_ext in that same cycle and compute next = branch_taken ? pc+immediate_ext : pc+4. Arithmetic is modulo 2^32, so wrap-around is silent.
  - If next[1:0]==0, load pc=next and go to REQ. Otherwise go to FAULT with pc unchanged.
- FAULT: fetch_fault=1. It stays there until reset and issues no requests.
- imem_rsp_valid outside WAIT is ignored. branch_taken and immediate_ext outside HOLD with instr_ready=1 are ignored.
- Reset mid-operation (any state) returns to IDLE immediately. Any outstanding memory response after reset release is dropped unless it arrives in WAIT of a new request.

## Timing
- First request: the edge after rst_n rises enters REQ. imem_req_valid is high in cycle 1 after release.
- Minimum fetch latency: REQ 1 cycle + WAIT 1 cycle, so instr_valid rises 2 cycles after REQ entry.
- Steady-state throughput is 1 instruction per 3 cycles when ready and valid signals are always high: REQ, WAIT, HOLD.
- instr_valid drops the cycle after a HOLD handshake. The new pc appears on imem_addr in that same cycle.
- Fault timing: fetch_fault asserts MAX_WAIT+1 cycles after WAIT entry when no response arrives.
- Misaligned target: fetch_fault asserts 1 cycle after the HOLD handshake.

## Test plan
- Reset release with all handshakes tied high.
  - imem_addr sequence must be 0x0, 0x4, 0x8.
  - instr_valid must pulse for 1 cycle every 3 cycles.
  - opcode must equal rsp_data[6:0].
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD with instruction 0x00A00093.
  - instruction and pc must stay constant.
  - No new request may be issued.
- Branch at pc=0x100 with branch_taken=1 and immediate_ext=0xFFFFFFF0: next imem_addr must be 0xF0. Repeat with immediate_ext=0x8: next imem_addr must be 0x108.
- Wrap and misalignment:
  - pc=0xFFFFFFFC with no branch: next address must be 0x0.
  - Branch with immediate_ext=0x6: fetch_fault=1 and no further requests.
- Timeout: use MAX_WAIT=15 and never assert rsp_valid. fetch_fault must assert exactly 16 cycles after WAIT entry and stay set until rst_n is pulsed.
- Async reset asserted mid-WAIT:
  - Outputs must clear immediately, without waiting for a clock edge.
  - After release, the first request must be at RESET_PC.
  - A stale rsp_valid arriving in IDLE or REQ must be ignored.
